// File: rtl/mult_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mult_arbiter_if
// Purpose  : Bundles the two requester channels and the shared multiplier
//            link seen by mult_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface mult_arbiter_if #(
    parameter int tamano = 8
) ();
    // Requester side
    logic                  REQ0;
    logic                  REQ1;
    logic [tamano-1:0]     A0;
    logic [tamano-1:0]     B0;
    logic [tamano-1:0]     A1;
    logic [tamano-1:0]     B1;
    logic                  ACK0;
    logic                  ACK1;
    logic                  ERR;
    logic [2*tamano-1:0]   RES;
    logic                  BUSY;
    // Shared multiplier side
    logic                  M_START;
    logic [tamano-1:0]     M_A;
    logic [tamano-1:0]     M_B;
    logic                  M_END;
    logic [2*tamano-1:0]   M_S;

    // Arbiter view
    modport slave (
        input  REQ0, REQ1, A0, B0, A1, B1, M_END, M_S,
        output ACK0, ACK1, ERR, RES, BUSY, M_START, M_A, M_B
    );

    // Environment view (requesters plus multiplier)
    modport master (
        output REQ0, REQ1, A0, B0, A1, B1, M_END, M_S,
        input  ACK0, ACK1, ERR, RES, BUSY, M_START, M_A, M_B
    );
endinterface
`default_nettype wire

// File: rtl/mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mult_arbiter
// Purpose  : Round-robin arbiter sharing one multiplier between two
//            requesters, with a WAIT-cycle timeout that returns RES=0/ERR.
// Revision : 1.0 - initial release
// ============================================================================
module mult_arbiter #(
    parameter int tamano  = 8,
    parameter int TIMEOUT = 40
) (
    input  wire logic          CLOCK,
    input  wire logic          RESET,
    mult_arbiter_if.slave      bus
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic                   win_q,   win_d;    // 0: channel 0, 1: channel 1
    logic                   last_q,  last_d;   // channel served most recently
    logic [tamano-1:0]      opa_q,   opa_d;
    logic [tamano-1:0]      opb_q,   opb_d;
    logic [2*tamano-1:0]    res_q,   res_d;
    logic                   err_q,   err_d;
    logic [CNT_W-1:0]       cnt_q,   cnt_d;

    logic                   pick;              // arbitration result this cycle
    logic [CNT_W-1:0]       cnt_inc;

    // Lone requester wins; on a tie the channel that was not served last wins.
    assign pick    = (bus.REQ0 && bus.REQ1) ? ~last_q : bus.REQ1;
    assign cnt_inc = cnt_q + CNT_W'(1);

    // Outputs decoded from the registered state so reset clears them at once.
    assign bus.M_START = (state_q == S_LAUNCH);
    assign bus.ACK0    = (state_q == S_RESP) && !win_q;
    assign bus.ACK1    = (state_q == S_RESP) &&  win_q;
    assign bus.ERR     = (state_q == S_RESP) &&  err_q;
    assign bus.BUSY    = (state_q != S_IDLE);
    assign bus.M_A     = opa_q;
    assign bus.M_B     = opb_q;
    assign bus.RES     = res_q;

    // State and datapath registers; LAST resets to 1 so channel 0 wins the first tie.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_IDLE;
            win_q   <= 1'b0;
            last_q  <= 1'b1;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            last_q  <= last_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: arbitrate, launch, wait for M_END or timeout, respond.
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        last_d  = last_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.REQ0 || bus.REQ1) begin
                    win_d   = pick;
                    opa_d   = pick ? bus.A1 : bus.A0;
                    opb_d   = pick ? bus.B1 : bus.B0;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                cnt_d   = '0;
                err_d   = 1'b0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_inc;
                if (bus.M_END) begin
                    res_d   = bus.M_S;
                    state_d = S_RESP;
                end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
                    // Multiplier never answered: report a zero product with ERR.
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                last_d  = win_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_arbiter
// Purpose  : Self-checking bench for mult_arbiter with a behavioural
//            multiplier and a round-robin reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_arbiter;

    localparam int W  = 8;
    localparam int TO = 40;

    logic CLOCK = 1'b0;
    logic RESET = 1'b0;

    always #5 CLOCK = ~CLOCK;

    mult_arbiter_if #(.tamano(W)) bus ();

    mult_arbiter #(.tamano(W), .TIMEOUT(TO)) dut (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: channel served most recently (1 after reset).
    int last_m = 1;

    // Behavioural multiplier: M_END pulses mdelay cycles after the cycle following M_START.
    int mdelay = 1;
    int mcnt   = 0;
    always @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            mcnt      <= 0;
            bus.M_END <= 1'b0;
            bus.M_S   <= '0;
        end else begin
            bus.M_END <= 1'b0;
            if (bus.M_START) begin
                mcnt <= mdelay;
            end else if (mcnt > 0) begin
                mcnt <= mcnt - 1;
                if (mcnt == 1) begin
                    bus.M_END <= 1'b1;
                    bus.M_S   <= (2*W)'(bus.M_A) * (2*W)'(bus.M_B);
                end
            end
        end
    end

    function automatic int exp_win(input bit r0, input bit r1);
        if (r0 && !r1) return 0;
        if (r1 && !r0) return 1;
        return 1 - last_m;
    endfunction

    // Observed results of one operation
    int o_start_lat, o_nstart, o_ma, o_mb, o_ack, o_res, o_err, o_lat, o_both, o_unstable;

    // Runs one operation from the current negedge until its ACK, dropping the
    // winner's REQ at the ACK. Optionally rewrites A0 at relative cycle chg_at.
    task automatic observe(input int d, input int chg_at, input int chg_val);
        int t0;
        mdelay = d;
        o_start_lat = -1; o_nstart = 0; o_ma = -1; o_mb = -1; o_ack = -1;
        o_res = -1; o_err = -1; o_lat = -1; o_both = 0; o_unstable = 0; t0 = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge CLOCK);
            if (bus.ACK0 && bus.ACK1) o_both = 1;
            if (o_start_lat >= 0 && (int'(bus.M_A) != o_ma || int'(bus.M_B) != o_mb))
                o_unstable = 1;
            if (bus.M_START) begin
                o_nstart++;
                if (o_start_lat < 0) begin
                    o_start_lat = i; t0 = i;
                    o_ma = int'(bus.M_A); o_mb = int'(bus.M_B);
                end
            end
            if (bus.ACK0 || bus.ACK1) begin
                o_ack = bus.ACK1 ? 1 : 0;
                o_res = int'(bus.RES);
                o_err = int'(bus.ERR);
                o_lat = i - t0;
                if (o_ack == 0) bus.REQ0 = 1'b0; else bus.REQ1 = 1'b0;
                break;
            end
            if (i == chg_at) bus.A0 = W'(chg_val);
        end
    endtask

    task automatic test_reset();
        bus.REQ0 = 0; bus.REQ1 = 0; bus.A0 = 0; bus.B0 = 0; bus.A1 = 0; bus.B1 = 0;
        RESET = 1'b0;
        repeat (2) @(negedge CLOCK);
        n_checks++;
        if ({bus.BUSY, bus.M_START, bus.ACK0, bus.ACK1, bus.ERR} !== 5'b0)
            $display("FAIL reset_ctrl: got %b want 00000", {bus.BUSY, bus.M_START, bus.ACK0, bus.ACK1, bus.ERR});
        else n_pass++;
        n_checks++;
        if ({bus.RES, bus.M_A, bus.M_B} !== '0)
            $display("FAIL reset_data: RES=%0d M_A=%0d M_B=%0d want 0", bus.RES, bus.M_A, bus.M_B);
        else n_pass++;
        RESET = 1'b1;
        last_m = 1;
        @(negedge CLOCK);
        n_checks++;
        if (bus.BUSY !== 1'b0) $display("FAIL reset_idle_busy: got %b want 0", bus.BUSY);
        else n_pass++;
    endtask

    task automatic test_single();
        bus.REQ0 = 1; bus.A0 = 12; bus.B0 = 10;
        observe(9, 0, 0);
        n_checks++;
        if (o_start_lat !== 1 || o_nstart !== 1)
            $display("FAIL single_start: lat=%0d pulses=%0d want 1/1", o_start_lat, o_nstart);
        else n_pass++;
        n_checks++;
        if (o_ma !== 12 || o_mb !== 10) $display("FAIL single_ops: M_A=%0d M_B=%0d want 12/10", o_ma, o_mb);
        else n_pass++;
        n_checks++;
        if (o_ack !== 0 || o_res !== 120 || o_err !== 0)
            $display("FAIL single_resp: ack=%0d res=%0d err=%0d want 0/120/0", o_ack, o_res, o_err);
        else n_pass++;
        n_checks++;
        if (o_lat !== 11) $display("FAIL single_latency: got %0d want 11", o_lat);
        else n_pass++;
        last_m = 0;
    endtask

    task automatic test_tie();
        @(negedge CLOCK);
        RESET = 1'b0;
        @(negedge CLOCK);
        RESET = 1'b1;
        last_m = 1;
        bus.REQ0 = 1; bus.A0 = 3; bus.B0 = 5;
        bus.REQ1 = 1; bus.A1 = 7; bus.B1 = 9;
        observe(3, 0, 0);
        n_checks++;
        if (o_ack !== exp_win(1, 1) || o_res !== 15)
            $display("FAIL tie_first: ack=%0d res=%0d want %0d/15", o_ack, o_res, exp_win(1, 1));
        else n_pass++;
        last_m = 0;
        observe(5, 0, 0);
        n_checks++;
        if (o_ack !== 1 || o_res !== 63)
            $display("FAIL tie_second: ack=%0d res=%0d want 1/63", o_ack, o_res);
        else n_pass++;
        n_checks++;
        if (o_start_lat !== 2) $display("FAIL tie_gap: start after %0d cycles want 2", o_start_lat);
        else n_pass++;
        last_m = 1;
    endtask

    task automatic test_fairness();
        bus.REQ0 = 1; bus.A0 = 2; bus.B0 = 21;
        observe(2, 0, 0);
        n_checks++;
        if (o_ack !== 0 || o_res !== 42) $display("FAIL fair_pre: ack=%0d res=%0d want 0/42", o_ack, o_res);
        else n_pass++;
        last_m = 0;
        bus.REQ0 = 1; bus.A0 = 11; bus.B0 = 11;
        bus.REQ1 = 1; bus.A1 = 6;  bus.B1 = 7;
        observe(4, 0, 0);
        n_checks++;
        if (o_ack !== exp_win(1, 1) || o_res !== 42)
            $display("FAIL fair_grant: ack=%0d res=%0d want %0d/42", o_ack, o_res, exp_win(1, 1));
        else n_pass++;
        last_m = 1;
        observe(6, 0, 0);
        n_checks++;
        if (o_ack !== 0 || o_res !== 121) $display("FAIL fair_pending: ack=%0d res=%0d want 0/121", o_ack, o_res);
        else n_pass++;
        last_m = 0;
    endtask

    task automatic test_timeout();
        // M_END on the last allowed WAIT cycle still counts as success.
        bus.REQ1 = 1; bus.A1 = 9; bus.B1 = 9;
        observe(TO - 1, 0, 0);
        n_checks++;
        if (o_ack !== 1 || o_res !== 81 || o_err !== 0 || o_lat !== TO + 1)
            $display("FAIL timeout_edge_ok: ack=%0d res=%0d err=%0d lat=%0d want 1/81/0/%0d", o_ack, o_res, o_err, o_lat, TO + 1);
        else n_pass++;
        last_m = 1;
        // One cycle later M_END lands in RESP and must be ignored.
        bus.REQ1 = 1;
        observe(TO, 0, 0);
        n_checks++;
        if (o_ack !== 1 || o_res !== 0 || o_err !== 1 || o_lat !== TO + 1)
            $display("FAIL timeout_edge_err: ack=%0d res=%0d err=%0d lat=%0d want 1/0/1/%0d", o_ack, o_res, o_err, o_lat, TO + 1);
        else n_pass++;
        bus.REQ0 = 1; bus.A0 = 5; bus.B0 = 5;
        observe(1000, 0, 0);
        n_checks++;
        if (o_ack !== 0 || o_res !== 0 || o_err !== 1 || o_lat !== TO + 1)
            $display("FAIL timeout_stuck: ack=%0d res=%0d err=%0d lat=%0d want 0/0/1/%0d", o_ack, o_res, o_err, o_lat, TO + 1);
        else n_pass++;
        last_m = 0;
        @(negedge CLOCK);
        n_checks++;
        if (bus.BUSY !== 1'b0 || bus.ERR !== 1'b0)
            $display("FAIL timeout_idle: BUSY=%b ERR=%b want 0/0", bus.BUSY, bus.ERR);
        else n_pass++;
    endtask

    task automatic test_operand_change();
        bus.REQ0 = 1; bus.A0 = 12; bus.B0 = 10;
        observe(9, 4, 200);
        n_checks++;
        if (o_ma !== 12 || o_unstable !== 0)
            $display("FAIL operand_hold: M_A=%0d unstable=%0d want 12/0", o_ma, o_unstable);
        else n_pass++;
        n_checks++;
        if (o_ack !== 0 || o_res !== 120) $display("FAIL operand_res: ack=%0d res=%0d want 0/120", o_ack, o_res);
        else n_pass++;
        last_m = 0;
    endtask

    task automatic test_reset_mid_wait();
        int seen;
        int acks;
        int busy;
        seen = 0; acks = 0; busy = 0;
        mdelay = 100;
        bus.REQ0 = 1; bus.A0 = 4; bus.B0 = 4;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLOCK);
            if (bus.M_START) begin seen = 1; break; end
        end
        n_checks++;
        if (seen !== 1) $display("FAIL rstwait_start: seen=%0d want 1", seen);
        else n_pass++;
        repeat (5) @(negedge CLOCK);
        RESET = 1'b0;
        #1;
        n_checks++;
        if ({bus.BUSY, bus.M_START, bus.ACK0, bus.ACK1, bus.ERR} !== 5'b0 || bus.RES !== '0)
            $display("FAIL rstwait_clear: ctrl=%b RES=%0d want 00000/0", {bus.BUSY, bus.M_START, bus.ACK0, bus.ACK1, bus.ERR}, bus.RES);
        else n_pass++;
        bus.REQ0 = 0;
        @(negedge CLOCK);
        RESET = 1'b1;
        last_m = 1;
        for (int i = 0; i < 60; i++) begin
            @(negedge CLOCK);
            if (bus.ACK0 || bus.ACK1) acks++;
            if (bus.BUSY) busy++;
        end
        n_checks++;
        if (acks !== 0 || busy !== 0) $display("FAIL rstwait_noack: acks=%0d busy=%0d want 0/0", acks, busy);
        else n_pass++;
    endtask

    task automatic test_random();
        int ew, ea, eb, d, ok, exp_lat, exp_start;
        exp_start = 1;
        for (int it = 0; it < 30; it++) begin
            if (!bus.REQ0 && ($urandom_range(0, 1) == 1)) begin
                bus.REQ0 = 1; bus.A0 = W'($urandom_range(0, 255)); bus.B0 = W'($urandom_range(0, 255));
            end
            if (!bus.REQ1 && ($urandom_range(0, 1) == 1)) begin
                bus.REQ1 = 1; bus.A1 = W'($urandom_range(0, 255)); bus.B1 = W'($urandom_range(0, 255));
            end
            if (!bus.REQ0 && !bus.REQ1) begin
                bus.REQ0 = 1; bus.A0 = W'($urandom_range(0, 255)); bus.B0 = W'($urandom_range(0, 255));
            end
            ew = exp_win(bus.REQ0, bus.REQ1);
            ea = (ew == 0) ? int'(bus.A0) : int'(bus.A1);
            eb = (ew == 0) ? int'(bus.B0) : int'(bus.B1);
            d  = $urandom_range(1, TO + 5);
            ok = (d <= TO - 1) ? 1 : 0;
            exp_lat = ok ? d + 2 : TO + 1;
            observe(d, 0, 0);
            n_checks++;
            if (o_ack !== ew || o_ma !== ea || o_mb !== eb)
                $display("FAIL rand_grant[%0d]: ack=%0d M_A=%0d M_B=%0d want %0d/%0d/%0d", it, o_ack, o_ma, o_mb, ew, ea, eb);
            else n_pass++;
            n_checks++;
            if (o_res !== (ok ? ea * eb : 0) || o_err !== (1 - ok))
                $display("FAIL rand_result[%0d]: res=%0d err=%0d want %0d/%0d", it, o_res, o_err, ok ? ea * eb : 0, 1 - ok);
            else n_pass++;
            n_checks++;
            if (o_lat !== exp_lat || o_start_lat !== exp_start || o_nstart !== 1)
                $display("FAIL rand_timing[%0d]: lat=%0d start=%0d pulses=%0d want %0d/%0d/1", it, o_lat, o_start_lat, o_nstart, exp_lat, exp_start);
            else n_pass++;
            n_checks++;
            if (o_both !== 0 || o_unstable !== 0)
                $display("FAIL rand_hazard[%0d]: both_ack=%0d unstable=%0d want 0/0", it, o_both, o_unstable);
            else n_pass++;
            last_m = ew;
            exp_start = 2;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_fairness();
        test_timeout();
        test_operand_change();
        test_reset_mid_wait();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
